regfile_writeback_queue: RTL and testbench

- Write-side companion to the 32x32 register file. Accepts register write requests from the multicycle datapath through a valid/ready handshake.
- Buffers requests in order in a small FIFO and drains one per cycle onto the register file's write port (write strobe, one-hot enable, data).
- Exports a per-register pending mask so the control FSM can stall reads of registers with writes still in flight.

---
 rtl/regfile_writeback_queue_if.sv | 24 ++
 rtl/regfile_writeback_queue.sv | 99 +++++++++
 tb/tb_regfile_writeback_queue.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_writeback_queue_if.sv
// Request handshake and register-file write bus for the writeback queue.
// The master side issues requests; the slave side is the queue.
interface regfile_writeback_queue_if #(
  parameter int WORD_LENGTH = 32,
  parameter int ADDR_WIDTH  = 5
);
  logic                       req_valid;
  logic                       req_ready;
  logic [ADDR_WIDTH-1:0]      req_addr;
  logic [WORD_LENGTH-1:0]     req_data;
  logic                       rf_write;
  logic [(2**ADDR_WIDTH)-1:0] rf_enable;
  logic [WORD_LENGTH-1:0]     rf_data;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, rf_write, rf_enable, rf_data
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, rf_write, rf_enable, rf_data
  );
endinterface

// File: rtl/regfile_writeback_queue.sv
// In-order write queue in front of the register file write port: drains one
// entry per cycle and reports which registers still have writes in flight.
module regfile_writeback_queue #(
  parameter int WORD_LENGTH = 32,
  parameter int DEPTH       = 4,
  parameter int ADDR_WIDTH  = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  regfile_writeback_queue_if.slave   bus,
  input  logic                       flush,
  output logic [(2**ADDR_WIDTH)-1:0] pending_mask,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       busy
);
  localparam int NREG  = 2**ADDR_WIDTH;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0]  addr_mem [DEPTH];
  logic [WORD_LENGTH-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]       slot_valid;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic                   push;
  logic                   store;
  logic                   pop;

  assign bus.req_ready = reset & ~flush & (count != CNT_W'(DEPTH));
  assign push          = bus.req_valid & bus.req_ready;
  // Writes to register 0 complete the handshake but are discarded.
  assign store         = push & (bus.req_addr != '0);
  assign pop           = (count != '0) & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      slot_valid <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      slot_valid <= '0;
    end else begin
      if (store) begin
        wr_ptr             <= wr_ptr + 1'b1;
        slot_valid[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr             <= rd_ptr + 1'b1;
        slot_valid[rd_ptr] <= 1'b0;
      end
      case ({store, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      addr_mem[wr_ptr] <= bus.req_addr;
      data_mem[wr_ptr] <= bus.req_data;
    end
  end

  // Output stage holds each write for exactly one cycle; rf_data keeps its last value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rf_write  <= 1'b0;
      bus.rf_enable <= '0;
      bus.rf_data   <= '0;
    end else if (flush) begin
      bus.rf_write  <= 1'b0;
      bus.rf_enable <= '0;
    end else if (pop) begin
      bus.rf_write  <= 1'b1;
      bus.rf_enable <= NREG'(1) << addr_mem[rd_ptr];
      bus.rf_data   <= data_mem[rd_ptr];
    end else begin
      bus.rf_write  <= 1'b0;
      bus.rf_enable <= '0;
    end
  end

  always_comb begin
    pending_mask = bus.rf_write ? bus.rf_enable : '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i]) begin
        pending_mask = pending_mask | (NREG'(1) << addr_mem[i]);
      end
    end
  end

  assign busy = (count != '0) | bus.rf_write;
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue: each step drives inputs, then
// checks outputs one time unit after the rising edge against hand-computed values.
module tb_regfile_writeback_queue;
  logic        clk;
  logic        reset;
  logic        flush;
  logic [31:0] pending_mask;
  logic [2:0]  count;
  logic        busy;
  int          total;
  int          bad;

  regfile_writeback_queue_if #(.WORD_LENGTH(32), .ADDR_WIDTH(5)) wb ();

  regfile_writeback_queue #(.WORD_LENGTH(32), .DEPTH(4), .ADDR_WIDTH(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (wb.slave),
    .flush        (flush),
    .pending_mask (pending_mask),
    .count        (count),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic valid, input logic [4:0] addr, input logic [31:0] data);
    wb.req_valid = valid;
    wb.req_addr  = addr;
    wb.req_data  = data;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    flush = 1'b0;
    apply_stimulus(1'b1, 5'd3, 32'h1);

    // reset state, with a request presented that must not be accepted
    #12;
    check_output("rst_ready",   64'(wb.req_ready), 64'h0);
    check_output("rst_write",   64'(wb.rf_write),  64'h0);
    check_output("rst_enable",  64'(wb.rf_enable), 64'h0);
    check_output("rst_data",    64'(wb.rf_data),   64'h0);
    check_output("rst_pending", 64'(pending_mask), 64'h0);
    check_output("rst_count",   64'(count),        64'h0);
    check_output("rst_busy",    64'(busy),         64'h0);
    apply_stimulus(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // single push addr 5
    apply_stimulus(1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    check_output("t1_ready", 64'(wb.req_ready), 64'h1);
    tick();
    apply_stimulus(1'b0, 5'd0, 32'h0);
    check_output("t1_count_q",   64'(count),        64'h1);
    check_output("t1_write_q",   64'(wb.rf_write),  64'h0);
    check_output("t1_pending_q", 64'(pending_mask), 64'h20);
    check_output("t1_busy_q",    64'(busy),         64'h1);
    tick();
    check_output("t1_write",   64'(wb.rf_write),  64'h1);
    check_output("t1_enable",  64'(wb.rf_enable), 64'h20);
    check_output("t1_data",    64'(wb.rf_data),   64'hDEADBEEF);
    check_output("t1_pending", 64'(pending_mask), 64'h20);
    check_output("t1_count",   64'(count),        64'h0);
    tick();
    check_output("t1_write_end",   64'(wb.rf_write),  64'h0);
    check_output("t1_enable_end",  64'(wb.rf_enable), 64'h0);
    check_output("t1_data_hold",   64'(wb.rf_data),   64'hDEADBEEF);
    check_output("t1_pending_end", 64'(pending_mask), 64'h0);
    check_output("t1_busy_end",    64'(busy),         64'h0);

    // back-to-back pushes addr 1..4
    for (int i = 1; i <= 4; i++) begin
      apply_stimulus(1'b1, 5'(i), 32'(i * 32'h11));
      tick();
      check_output("t2_count", 64'(count), 64'h1);
      if (i > 1) begin
        check_output("t2_write",  64'(wb.rf_write),  64'h1);
        check_output("t2_enable", 64'(wb.rf_enable), 64'(32'h1 << (i - 1)));
        check_output("t2_data",   64'(wb.rf_data),   64'((i - 1) * 32'h11));
      end
    end
    apply_stimulus(1'b0, 5'd0, 32'h0);
    tick();
    check_output("t2_enable_last", 64'(wb.rf_enable), 64'h10);
    check_output("t2_data_last",   64'(wb.rf_data),   64'h44);
    check_output("t2_count_last",  64'(count),        64'h0);
    tick();
    check_output("t2_write_end", 64'(wb.rf_write), 64'h0);

    // five requests in five cycles: never refused, drained in order
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 5'(10 + i), 32'(32'h100 + i));
      #1;
      check_output("t3_ready", 64'(wb.req_ready), 64'h1);
      tick();
      check_output("t3_count", 64'(count), 64'h1);
      if (i > 0) begin
        check_output("t3_enable", 64'(wb.rf_enable), 64'(32'h1 << (9 + i)));
        check_output("t3_data",   64'(wb.rf_data),   64'(32'h100 + i - 1));
      end
    end
    apply_stimulus(1'b0, 5'd0, 32'h0);
    tick();
    check_output("t3_enable_last", 64'(wb.rf_enable), 64'h4000);
    check_output("t3_data_last",   64'(wb.rf_data),   64'h104);
    tick();
    check_output("t3_busy_end", 64'(busy), 64'h0);

    // register 0 request is accepted and dropped
    apply_stimulus(1'b1, 5'd0, 32'h12345678);
    #1;
    check_output("t4_ready", 64'(wb.req_ready), 64'h1);
    tick();
    apply_stimulus(1'b0, 5'd0, 32'h0);
    check_output("t4_count",   64'(count),        64'h0);
    check_output("t4_pending", 64'(pending_mask), 64'h0);
    check_output("t4_write",   64'(wb.rf_write),  64'h0);
    check_output("t4_busy",    64'(busy),         64'h0);
    tick();
    check_output("t4_write_2", 64'(wb.rf_write), 64'h0);
    check_output("t4_data",    64'(wb.rf_data),  64'h104);

    // two writes to register 7, last one wins
    apply_stimulus(1'b1, 5'd7, 32'hA);
    tick();
    apply_stimulus(1'b1, 5'd7, 32'hB);
    tick();
    apply_stimulus(1'b0, 5'd0, 32'h0);
    check_output("t5_enable_a",  64'(wb.rf_enable), 64'h80);
    check_output("t5_data_a",    64'(wb.rf_data),   64'hA);
    check_output("t5_pending_a", 64'(pending_mask), 64'h80);
    tick();
    check_output("t5_write_b",   64'(wb.rf_write),  64'h1);
    check_output("t5_data_b",    64'(wb.rf_data),   64'hB);
    check_output("t5_pending_b", 64'(pending_mask), 64'h80);
    tick();
    check_output("t5_pending_end", 64'(pending_mask), 64'h0);
    check_output("t5_write_end",   64'(wb.rf_write),  64'h0);

    // flush with queued work and a request for register 9 in the flush cycle
    for (int i = 1; i <= 3; i++) begin
      apply_stimulus(1'b1, 5'(i), 32'(32'h300 + i));
      tick();
    end
    check_output("t6_pending_pre", 64'(pending_mask), 64'hC);
    apply_stimulus(1'b1, 5'd9, 32'h999);
    flush = 1'b1;
    #1;
    check_output("t6_ready_flush", 64'(wb.req_ready), 64'h0);
    tick();
    flush = 1'b0;
    apply_stimulus(1'b0, 5'd0, 32'h0);
    check_output("t6_count",   64'(count),        64'h0);
    check_output("t6_write",   64'(wb.rf_write),  64'h0);
    check_output("t6_enable",  64'(wb.rf_enable), 64'h0);
    check_output("t6_pending", 64'(pending_mask), 64'h0);
    check_output("t6_busy",    64'(busy),         64'h0);
    tick();
    check_output("t6_write_2", 64'(wb.rf_write), 64'h0);
    check_output("t6_data_2",  64'(wb.rf_data),  64'h302);

    // asynchronous reset in the middle of a drain
    apply_stimulus(1'b1, 5'd6, 32'h66);
    tick();
    apply_stimulus(1'b1, 5'd8, 32'h88);
    tick();
    apply_stimulus(1'b0, 5'd0, 32'h0);
    check_output("t7_write_pre",   64'(wb.rf_write),  64'h1);
    check_output("t7_pending_pre", 64'(pending_mask), 64'h140);
    #2;
    reset = 1'b0;
    #1;
    check_output("t7_write",   64'(wb.rf_write),  64'h0);
    check_output("t7_enable",  64'(wb.rf_enable), 64'h0);
    check_output("t7_data",    64'(wb.rf_data),   64'h0);
    check_output("t7_pending", 64'(pending_mask), 64'h0);
    check_output("t7_count",   64'(count),        64'h0);
    check_output("t7_busy",    64'(busy),         64'h0);
    check_output("t7_ready",   64'(wb.req_ready), 64'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check_output("t7_write_after", 64'(wb.rf_write), 64'h0);
    check_output("t7_busy_after",  64'(busy),        64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
